// File: rtl/num2char_pkg.sv
// Shared types and elaboration helpers for the binary-to-decimal ASCII serialiser.
package num2char_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2,
    TERM = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Decimal digits needed to print 2^bw - 1, i.e. floor(bw*log10(2)) + 1.
  function automatic int digits_needed(input int bw);
    return int'((longint'(bw) * 64'sd30103) / 64'sd100000) + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every BCD digit >= 5,
// then shift the BCD vector left by one with the next binary bit entering at bit 0.
module bcd_dabble_step #(
  parameter int DW = 10
) (
  input  logic [4*DW-1:0] bcd_i,
  input  logic            msb_i,
  output logic [4*DW-1:0] bcd_o
);

  logic [4*DW-1:0] adj;
  // The corrected MS bit is always 0 when DW is large enough for the input width.
  logic            unused_top;

  // Correct each digit, then shift in the incoming binary bit.
  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < DW; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
      end
    end
    bcd_o = {adj[4*DW-2:0], msb_i};
  end

  assign unused_top = adj[4*DW-1];

endmodule

// File: rtl/num2char_stream.sv
// Binary-to-decimal ASCII serialiser: sequential double-dabble conversion followed by
// MSD-first character streaming over valid/ready, with optional leading-zero
// suppression and an optional line terminator.
module num2char_stream
  import num2char_pkg::*;
#(
  parameter int         BW          = 32,
  parameter int         DW          = 10,
  parameter int         LZ_SUPPRESS = 1,
  parameter int         TERM_EN     = 1,
  parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start_update,
  input  logic [BW-1:0] value,
  output logic          busy,
  output logic [7:0]    char,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          last_o
);

  localparam int IW = (clog2(DW) < 1) ? 1 : clog2(DW);
  localparam int CW = clog2(BW + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(BW);
  localparam logic [IW-1:0] IDX_TOP  = IW'(DW - 1);

  if (BW < 4) begin : g_bw_check
    $error("num2char_stream: BW must be at least 4");
  end
  if (digits_needed(BW) > DW) begin : g_dw_check
    $error("num2char_stream: DW digits cannot hold a BW-bit value");
  end

  state_e          state_q, state_d;
  logic [BW-1:0]   bin_q,   bin_d;
  logic [4*DW-1:0] bcd_q,   bcd_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [IW-1:0]   idx_q,   idx_d;

  logic [4*DW-1:0] bcd_step;
  logic [IW-1:0]   msd;
  logic [3:0]      digit;

  bcd_dabble_step #(
    .DW (DW)
  ) u_step (
    .bcd_i (bcd_q),
    .msb_i (bin_q[BW-1]),
    .bcd_o (bcd_step)
  );

  // Locate the most significant non-zero digit and select the digit being emitted.
  always_comb begin
    msd   = '0;
    digit = '0;
    for (int i = 0; i < DW; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd = IW'(i);
      end
      if (idx_q == IW'(i)) begin
        digit = bcd_q[4*i +: 4];
      end
    end
  end

  // Next-state and output logic; the conversion spends BW shift cycles plus one
  // cycle on the finished BCD value to pick the starting digit.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy    = (state_q != IDLE);
    valid_o = 1'b0;
    last_o  = 1'b0;
    char    = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (start_update) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q != CNT_LAST) begin
          bcd_d = bcd_step;
          bin_d = {bin_q[BW-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
        end else begin
          // msd is 0 for a zero value, which still yields a single "0".
          idx_d   = (LZ_SUPPRESS != 0) ? msd : IDX_TOP;
          state_d = EMIT;
        end
      end
      EMIT: begin
        valid_o = 1'b1;
        char    = ASCII_ZERO + {4'h0, digit};
        last_o  = (idx_q == '0) && (TERM_EN == 0);
        if (ready_i) begin
          if (idx_q == '0) begin
            state_d = (TERM_EN != 0) ? TERM : IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      TERM: begin
        valid_o = 1'b1;
        char    = TERM_CHAR;
        last_o  = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_num2char_stream.sv
// Bench for num2char_stream: two instances (suppression+terminator, and full-width
// digits without terminator) share all inputs; a string-level model predicts each
// lane's character stream and timing, and a per-cycle compare checks both lanes.
module tb_num2char_stream;

  localparam int BW = 32;
  localparam int DW = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start_update = 1'b0;
  logic          ready_i = 1'b1;
  logic [BW-1:0] value = '0;

  logic          busy_w  [2];
  logic          valid_w [2];
  logic          last_w  [2];
  logic [7:0]    char_w  [2];

  int     checks   = 0;
  int     failures = 0;
  bit     mon_en   = 1'b0;
  longint cyc      = 0;

  always #5 CLK = ~CLK;

  num2char_stream #(
    .BW(BW), .DW(DW), .LZ_SUPPRESS(1), .TERM_EN(1), .TERM_CHAR(8'h0A)
  ) dut_a (
    .CLK(CLK), .RST(RST), .start_update(start_update), .value(value),
    .busy(busy_w[0]), .char(char_w[0]), .valid_o(valid_w[0]),
    .ready_i(ready_i), .last_o(last_w[0])
  );

  num2char_stream #(
    .BW(BW), .DW(DW), .LZ_SUPPRESS(0), .TERM_EN(0), .TERM_CHAR(8'h0A)
  ) dut_b (
    .CLK(CLK), .RST(RST), .start_update(start_update), .value(value),
    .busy(busy_w[1]), .char(char_w[1]), .valid_o(valid_w[1]),
    .ready_i(ready_i), .last_o(last_w[1])
  );

  initial forever begin
    @(posedge CLK);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic string vis(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = {r, "\\n"};
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  task automatic chk_str(input string name, input string got, input string exp);
    checks = checks + 1;
    if (got != exp) begin
      failures = failures + 1;
      $display("FAIL %s got=\"%s\" exp=\"%s\"", name, vis(got), vis(exp));
    end
  endtask

  // Expected character string computed with plain decimal arithmetic.
  function automatic string model_str(input longint v, input bit lz, input bit term);
    int    d [DW];
    int    msd;
    int    first;
    string s;
    longint x;
    x   = v;
    msd = 0;
    s   = "";
    for (int i = 0; i < DW; i++) begin
      d[i] = int'(x % 10);
      x    = x / 10;
      if (d[i] != 0) msd = i;
    end
    first = lz ? msd : DW - 1;
    for (int i = first; i >= 0; i--) s = $sformatf("%s%c", s, 8'h30 + d[i]);
    if (term) s = $sformatf("%s%c", s, 8'h0A);
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam bit LZ = (g == 0);
    localparam bit TM = (g == 0);
    byte unsigned q[$];
    bit       m_busy   = 1'b0;
    int       m_wait   = 0;
    string    recv     = "";
    int       hs_n     = 0;
    longint   acc_edge = 0;
    longint   first_v  = -1;
    longint   first_hs = -1;
    longint   last_hs  = -1;
    logic [7:0] pchar  = 8'h00;
    logic       pval   = 1'b0;
    logic       prdy   = 1'b0;
    string    pfx;
    string    s;

    initial begin
      pfx = (g == 0) ? "a_" : "b_";
      forever begin
        @(negedge CLK);
        if (mon_en) begin
          chk({pfx, "busy"}, busy_w[g], m_busy);
          chk({pfx, "valid"}, valid_w[g], m_busy && m_wait == 0);
          if (m_busy && m_wait == 0) begin
            if (q.size() > 0) begin
              chk({pfx, "char"}, char_w[g], q[0]);
              chk({pfx, "last"}, last_w[g], q.size() == 1);
            end
            if (first_v < 0) first_v = cyc;
          end
          if (pval && !prdy) begin
            chk({pfx, "stall_char"}, char_w[g], pchar);
            chk({pfx, "stall_valid"}, valid_w[g], 1);
          end
          pchar = char_w[g];
          pval  = valid_w[g];
          prdy  = ready_i;
          // Advance the model across the coming rising edge.
          if (!RST) begin
            q.delete();
            m_busy = 1'b0;
            m_wait = 0;
            pval   = 1'b0;
          end else if (!m_busy) begin
            if (start_update) begin
              s = model_str(longint'(value), LZ, TM);
              q.delete();
              for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
              m_busy   = 1'b1;
              m_wait   = BW + 1;
              acc_edge = cyc + 1;
              first_v  = -1;
              first_hs = -1;
            end
          end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
          end else if (ready_i) begin
            recv = $sformatf("%s%c", recv, char_w[g]);
            void'(q.pop_front());
            hs_n = hs_n + 1;
            if (first_hs < 0) first_hs = cyc + 1;
            last_hs = cyc + 1;
            if (q.size() == 0) m_busy = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_recv();
    mon[0].recv = "";
    mon[1].recv = "";
  endtask

  task automatic pulse_start(input logic [BW-1:0] v);
    value        = v;
    start_update = 1'b1;
    tick();
    start_update = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int lim);
    int n;
    n = 0;
    while ((mon[0].m_busy || mon[1].m_busy) && n < lim) begin
      tick();
      n = n + 1;
    end
    chk({name, "_timeout"}, n >= lim, 0);
    tick();
  endtask

  initial begin
    longint prev_last;
    int     n;
    int     h0;
    logic [6:0] pat;

    // Reset state
    RST     = 1'b0;
    ready_i = 1'b1;
    repeat (2) tick();
    chk("rst_busy_a", busy_w[0], 0);
    chk("rst_valid_a", valid_w[0], 0);
    chk("rst_last_a", last_w[0], 0);
    chk("rst_char_a", char_w[0], 8'h00);
    chk("rst_valid_b", valid_w[1], 0);
    mon_en = 1'b1;
    RST    = 1'b1;
    tick();

    // Pin the model itself
    chk_str("model_zero", model_str(0, 1, 1), "0\n");
    chk_str("model_1234_full", model_str(1234, 0, 0), "0000001234");

    // Zero value
    clear_recv();
    pulse_start(32'd0);
    wait_idle("t_zero", 200);
    chk_str("t_zero_a", mon[0].recv, "0\n");
    chk_str("t_zero_b", mon[1].recv, "0000000000");
    chk("t_zero_latency", mon[0].first_v - mon[0].acc_edge, 33);

    // Max value, back-to-back
    clear_recv();
    pulse_start(32'hFFFF_FFFF);
    wait_idle("t_max", 200);
    chk_str("t_max_a", mon[0].recv, "4294967295\n");
    chk_str("t_max_b", mon[1].recv, "4294967295");
    chk("t_max_first_hs", mon[0].first_hs - mon[0].acc_edge, 34);
    chk("t_max_burst", mon[0].last_hs - mon[0].first_hs, 10);

    // 1234
    clear_recv();
    pulse_start(32'd1234);
    wait_idle("t_1234", 200);
    chk_str("t_1234_a", mon[0].recv, "1234\n");
    chk_str("t_1234_b", mon[1].recv, "0000001234");

    // 90210 with a stalling sink
    clear_recv();
    pat = 7'b1010011;
    pulse_start(32'd90210);
    n = 0;
    while ((mon[0].m_busy || mon[1].m_busy) && n < 400) begin
      ready_i = pat[6 - (n % 7)];
      tick();
      n = n + 1;
    end
    chk("t_stall_timeout", n >= 400, 0);
    ready_i = 1'b1;
    tick();
    chk_str("t_stall_a", mon[0].recv, "90210\n");
    chk_str("t_stall_b", mon[1].recv, "0000090210");

    // start_update held high with a changing value
    clear_recv();
    value        = 32'd4321;
    start_update = 1'b1;
    tick();
    n = 0;
    while (mon[0].m_busy && n < 200) begin
      value = value + 32'd1111;
      tick();
      n = n + 1;
    end
    chk("t_hold_timeout", n >= 200, 0);
    prev_last = mon[0].last_hs;
    value     = 32'd55;
    tick();
    start_update = 1'b0;
    wait_idle("t_hold", 300);
    chk_str("t_hold_a", mon[0].recv, "4321\n55\n");
    chk_str("t_hold_b", mon[1].recv, "0000004321");
    chk("t_hold_reaccept", mon[0].acc_edge - prev_last, 1);

    // Reset during the third character of 987654
    clear_recv();
    h0 = mon[0].hs_n;
    pulse_start(32'd987654);
    n = 0;
    while ((mon[0].hs_n - h0) < 2 && n < 200) begin
      tick();
      n = n + 1;
    end
    chk("t_abort_timeout", n >= 200, 0);
    RST = 1'b0;
    tick();
    chk("t_abort_valid_a", valid_w[0], 0);
    chk("t_abort_busy_a", busy_w[0], 0);
    chk("t_abort_busy_b", busy_w[1], 0);
    chk("t_abort_char_a", char_w[0], 8'h00);
    chk_str("t_abort_partial", mon[0].recv, "98");
    RST = 1'b1;
    tick();
    clear_recv();
    pulse_start(32'd5);
    wait_idle("t_after", 200);
    chk_str("t_after_a", mon[0].recv, "5\n");
    chk_str("t_after_b", mon[1].recv, "0000000005");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/num2char_stream.md
Name: num2char_stream

Overview:
- Parametrised binary-to-decimal ASCII serialiser for the Oneseg BCD/display path.
- Accepts one unsigned binary value per request, for example an error-rate counter.
- Converts it with a sequential double-dabble, one bit per cycle.
- Streams the decimal digits MSD-first as ASCII characters over a valid/ready handshake.
- Optional leading-zero suppression and an optional line terminator.
- Feeds a UART/LCD character sink that may stall.

Parameters:
- BW, 32, input value width in bits (>=4).
- DW, 10, number of BCD digits. Elaboration error if 10^DW < 2^BW.
- LZ_SUPPRESS, 1, 1 = omit leading zero digits, always keeping at least the LS digit; 0 = emit all DW digits.
- TERM_EN, 1, 1 = append TERM_CHAR after the last digit.
- TERM_CHAR, 8'h0A, terminator character.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-low reset.
- start_update  in  1  conversion request pulse/level; sampled only in IDLE.
- value  in  BW  unsigned binary value; captured on the accepted start_update edge.
- busy  out  1  high from the accept edge until the final character handshake completes.
- char  out  8  ASCII character.
- valid_o  out  1  char is valid.
- ready_i  in  1  sink accepts char when valid_o && ready_i at a rising edge.
- last_o  out  1  qualifies the final character of the string (terminator if TERM_EN, else LS digit).

Behaviour:
- Reset: the design is synchronous with one clock; reset is synchronous and active-low. On the first edge with RST=0:
  - state=IDLE
  - busy=0, valid_o=0, last_o=0, char=8'h00
  - shift/BCD registers cleared
- Reset mid-conversion or mid-emission aborts the operation. No partial characters are emitted afterwards.
- States: IDLE, CONV, EMIT, TERM.
- IDLE:
  - start_update=1 → capture value into the shift register, clear the BCD register (DW*4 bits), bit counter=0, busy=1, go to CONV.
  - start_update while not IDLE is ignored. It is not queued.
- CONV, each cycle:
  - Apply add-3 to every BCD digit >=5.
  - Then shift {bcd,bin} left by 1.
  - Increment the counter.
  - After exactly BW cycles, go to EMIT.
  - In the last CONV cycle, compute the index of the most significant non-zero digit (msd).
  - If LZ_SUPPRESS=0, or the value is 0, the start index is DW-1 or 0 respectively, giving "0" for zero with suppression on.
- Latency: if start is accepted at edge E0, the first valid_o=1 appears after edge E0+BW+1.
- EMIT:
  - char = 8'h30 + digit[idx], valid_o=1.
  - On handshake with idx==0: go to TERM if TERM_EN, else go to IDLE.
  - On handshake otherwise: idx decrements and the next char is presented in the following cycle. Back-to-back transfers run at 1 char/cycle when ready_i stays high.
- TERM: char=TERM_CHAR, valid_o=1, last_o=1. On handshake go to IDLE.
- last_o is high in EMIT only when idx==0 and TERM_EN=0.
- Stall: while valid_o && !ready_i, char, last_o and valid_o hold stable. valid_o never drops without a handshake, except on reset.
- Handshake completion edge: valid_o and busy fall on the edge that completes the final handshake.
  - A start_update present in that same cycle is ignored.
  - The earliest accept is the following IDLE cycle.
- Widths:
  - Digit extraction is a 4-bit slice of a 4*DW register indexed by idx, idx width = clog2(DW).
  - ASCII addition is 8-bit.
  - No digit exceeds 9 after conversion, so no overflow.

Decomposition:
- Package num2char_pkg:
  - state enum {IDLE, CONV, EMIT, TERM}
  - ASCII_ZERO=8'h30
  - clog2 function
  - a digits_needed(BW) function used for the elaboration check
- Sub-module bcd_dabble_step: combinational, parameter DW. It takes {bcd[4*DW-1:0], msb_in} and returns the corrected, shifted bcd. It is instantiated once inside the CONV datapath.

Test Plan:
- Value 0, LZ_SUPPRESS=1, TERM_EN=1 → exactly "0","\n" (8'h30, 8'h0A); last_o only on 8'h0A; first valid at E0+33.
- 32'hFFFFFFFF, ready_i=1 → "4294967295\n" on 11 consecutive cycles; busy falls with the '\n' handshake.
- 1234, LZ_SUPPRESS=0, TERM_EN=0 → "0000001234"; last_o on '4'.
- 90210, ready_i toggled randomly (e.g. 1010011) → sequence "90210\n" unchanged; char stable during every stall cycle.
- start_update held high for the whole operation with value changing → exactly one string, for the value at the accept edge; the next string starts only after IDLE is re-entered.
- RST=0 asserted during the 3rd EMIT char of 987654 → next edge: valid_o=0, busy=0; a new start with 5 → "5\n" only.
